// File: rtl/ahb2apb_bridge.sv
// AHB-to-APB bridge: one AHB slave port, one APB requester port.
// Every AHB transfer becomes one APB setup/access sequence, with AHB wait states
// inserted until the APB completer answers. A completer error is returned as a
// two-cycle AHB ERROR response. All outputs come straight from registers.
module ahb2apb_bridge #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  HSEL,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic [DATA_WIDTH-1:0] HWDATA,
   input  logic                  HREADY,
   output logic                  HREADYOUT,
   output logic [1:0]            HRESP,
   output logic [DATA_WIDTH-1:0] HRDATA,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [DATA_WIDTH-1:0] PWDATA,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERR
);

   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [1:0] RESP_ERROR = 2'b01;

   typedef enum logic [2:0] {
      IDLE, WLATCH, SETUP, ACCESS, ERR1, ERR2
   } state_t;

   state_t state;
   logic   valid;
   logic   unused_htrans0;

   // NONSEQ and SEQ both start a transfer; only HTRANS[1] separates them from IDLE/BUSY.
   assign valid          = HSEL & HREADY & HTRANS[1];
   assign unused_htrans0 = HTRANS[0];

   // Bridge FSM; every bus output is updated here so nothing combinational reaches a pin.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state     <= IDLE;
         HREADYOUT <= 1'b1;
         HRESP     <= RESP_OKAY;
         HRDATA    <= '0;
         PADDR     <= '0;
         PSEL      <= 1'b0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PWDATA    <= '0;
      end else begin
         case (state)
            // ERR2 is the second error cycle but already ready, so a new
            // transfer is accepted there just as in IDLE.
            IDLE, ERR2: begin
               HRESP     <= RESP_OKAY;
               HREADYOUT <= 1'b1;
               PSEL      <= 1'b0;
               PENABLE   <= 1'b0;
               state     <= IDLE;
               if (valid) begin
                  PADDR     <= HADDR;
                  PWRITE    <= HWRITE;
                  HREADYOUT <= 1'b0;
                  // Reads go straight to SETUP; writes first wait for the data phase.
                  PSEL      <= ~HWRITE;
                  state     <= HWRITE ? WLATCH : SETUP;
               end
            end
            // Write data only becomes valid in the AHB data phase.
            WLATCH: begin
               PWDATA <= HWDATA;
               PSEL   <= 1'b1;
               state  <= SETUP;
            end
            SETUP: begin
               PENABLE <= 1'b1;
               state   <= ACCESS;
            end
            // Hold the APB access until the completer is ready.
            ACCESS: begin
               if (PREADY) begin
                  PSEL    <= 1'b0;
                  PENABLE <= 1'b0;
                  if (PSLVERR) begin
                     HRESP <= RESP_ERROR;
                     state <= ERR1;
                  end else begin
                     HREADYOUT <= 1'b1;
                     if (!PWRITE) HRDATA <= PRDATA;
                     state <= IDLE;
                  end
               end
            end
            // First error cycle: ERROR with HREADYOUT low, as AHB requires.
            ERR1: begin
               HREADYOUT <= 1'b1;
               state     <= ERR2;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Randomized scoreboard bench for ahb2apb_bridge: the master pushes the expected
// APB access and AHB completion for each transfer; an APB completer and an AHB
// monitor pop and compare them independently.
module tb_ahb2apb_bridge;

   logic        HCLK = 1'b0;
   logic        HRESET, HSEL, HWRITE, HREADY;
   logic [31:0] HADDR, HWDATA, HRDATA, PADDR, PWDATA, PRDATA;
   logic [1:0]  HTRANS, HRESP;
   logic        HREADYOUT, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

   ahb2apb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
      .HRESP(HRESP), .HRDATA(HRDATA), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
      .PSLVERR(PSLVERR)
   );

   always #5 HCLK = ~HCLK;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
      int          waits;
      logic        err;
      logic [31:0] rdata;
   } apb_t;

   typedef struct {
      logic        wr;
      logic        err;
      logic [31:0] rdata;
      int          due;
   } ahb_t;

   apb_t        apb_q[$];
   ahb_t        ahb_q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   bit          rst_test = 1'b1;
   logic [31:0] exp_hrdata = '0;

   initial forever begin
      @(posedge HCLK);
      cyc++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // any=1: fully random bus (only used while the bridge is busy and ignoring it);
   // any=0: random but never a valid transfer.
   task automatic set_junk(input bit any);
      HADDR  = $urandom;
      HWRITE = 1'($urandom);
      HSEL   = 1'($urandom);
      HTRANS = 2'($urandom);
      HREADY = 1'($urandom);
      if (!any) begin
         case ($urandom_range(0, 2))
            0: HSEL = 1'b0;
            1: HREADY = 1'b0;
            default: HTRANS = {1'b0, 1'($urandom)};
         endcase
      end
   endtask

   // Issue one transfer: expectations come from the transfer's own parameters.
   task automatic issue(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                        input int waits, input logic err, input logic [31:0] rdata,
                        input int idles);
      int n = 0;
      while (!HREADYOUT && n < 200) begin
         set_junk(1);
         HWDATA = $urandom;
         @(negedge HCLK);
         n++;
      end
      checks++;
      if (!HREADYOUT) begin
         errors++;
         $display("FAIL ready_timeout: got HREADYOUT=0 expected 1 within 200 cycles");
      end
      for (int i = 0; i < idles; i++) begin
         set_junk(0);
         @(negedge HCLK);
         chk("idle_psel", 32'(PSEL), 32'd0);
         chk("idle_hreadyout", 32'(HREADYOUT), 32'd1);
      end
      HSEL   = 1'b1;
      HREADY = 1'b1;
      HTRANS = 2'($urandom_range(2, 3));
      HADDR  = addr;
      HWRITE = wr;
      HWDATA = $urandom;
      apb_q.push_back('{addr, wr, wdata, waits, err, rdata});
      ahb_q.push_back('{wr, err, rdata, cyc + (wr ? 4 : 3) + waits + (err ? 1 : 0)});
      @(negedge HCLK);
      HWDATA = wdata;
      set_junk(1);
      @(negedge HCLK);
   endtask

   // APB completer: inserts the requested wait states and checks the access.
   initial begin
      int   wcnt = 0;
      apb_t a;
      PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
      forever begin
         @(negedge HCLK);
         if (PSEL && PENABLE && apb_q.size() > 0) begin
            a = apb_q[0];
            chk("paddr", PADDR, a.addr);
            chk("pwrite", 32'(PWRITE), 32'(a.wr));
            if (a.wr) chk("pwdata", PWDATA, a.wdata);
            if (wcnt < a.waits) begin
               PREADY = 1'b0; PSLVERR = 1'($urandom); PRDATA = $urandom;
               wcnt++;
            end else begin
               PREADY = 1'b1; PSLVERR = a.err; PRDATA = a.rdata;
               wcnt = 0;
               void'(apb_q.pop_front());
            end
         end else begin
            if (PSEL && PENABLE) begin
               checks++; errors++;
               $display("FAIL unexpected_apb_access: got PADDR=%h expected no access", PADDR);
            end
            PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
         end
      end
   end

   // AHB monitor: a HREADYOUT 0->1 edge marks the end of a transfer.
   initial begin
      logic       prev_ro = 1'b1;
      logic [1:0] prev_resp = 2'b00;
      ahb_t       e;
      forever begin
         @(negedge HCLK);
         if (!rst_test) begin
            if (!prev_ro && HREADYOUT) begin
               if (ahb_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_completion: got completion expected none");
               end else begin
                  e = ahb_q.pop_front();
                  chk("latency", 32'(cyc), 32'(e.due));
                  chk("hresp_done", 32'(HRESP), e.err ? 32'd1 : 32'd0);
                  chk("hresp_prev", 32'(prev_resp), e.err ? 32'd1 : 32'd0);
                  if (!e.wr && !e.err) exp_hrdata = e.rdata;
               end
            end
            chk("hrdata", HRDATA, exp_hrdata);
         end
         prev_ro   = HREADYOUT;
         prev_resp = HRESP;
      end
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish expected finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

   initial begin
      int n;
      HRESET = 1'b1;
      HWDATA = '0;
      set_junk(0);
      repeat (3) @(negedge HCLK);
      chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
      chk("rst_hresp", 32'(HRESP), 32'd0);
      chk("rst_psel", 32'(PSEL), 32'd0);
      chk("rst_penable", 32'(PENABLE), 32'd0);
      chk("rst_paddr", PADDR, 32'd0);
      chk("rst_hrdata", HRDATA, 32'd0);
      HRESET = 1'b0;
      @(negedge HCLK);
      rst_test = 1'b0;

      // Directed: plain read, plain write, stretched read, error then back-to-back read.
      issue(32'h4000_0010, 1'b0, 32'h0, 0, 1'b0, 32'hDEAD_BEEF, 1);
      issue(32'h4000_0004, 1'b1, 32'h1234_5678, 0, 1'b0, 32'h0BAD_0BAD, 1);
      issue(32'h4000_0020, 1'b0, 32'h0, 3, 1'b0, 32'hCAFE_F00D, 0);
      issue(32'h4000_0030, 1'b0, 32'h0, 0, 1'b1, 32'h5555_AAAA, 0);
      issue(32'h4000_0040, 1'b0, 32'h0, 0, 1'b0, 32'h0123_4567, 0);
      issue(32'h4000_0050, 1'b1, 32'hA5A5_5A5A, 1, 1'b1, 32'h0, 0);
      issue(32'h4000_0060, 1'b1, 32'h0F0F_F0F0, 0, 1'b0, 32'h0, 0);

      for (int i = 0; i < 200; i++)
         issue($urandom, 1'($urandom), $urandom, $urandom_range(0, 3),
               ($urandom_range(0, 4) == 0), $urandom,
               ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3));

      n = 0;
      while (ahb_q.size() > 0 && n < 200) begin
         set_junk(!HREADYOUT);
         @(negedge HCLK);
         n++;
      end
      chk("drain_pending", 32'(ahb_q.size()), 32'd0);
      set_junk(0);
      @(negedge HCLK);

      // Reset in the middle of a long APB access.
      HSEL = 1'b1; HREADY = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h4000_0070;
      apb_q.push_back('{32'h4000_0070, 1'b0, 32'h0, 1000, 1'b0, 32'h0});
      rst_test = 1'b1;
      @(negedge HCLK);
      set_junk(0);
      n = 0;
      while (!PENABLE && n < 20) begin
         @(negedge HCLK);
         n++;
      end
      chk("reach_access", 32'(PENABLE), 32'd1);
      HRESET = 1'b1;
      @(negedge HCLK);
      chk("mid_rst_psel", 32'(PSEL), 32'd0);
      chk("mid_rst_penable", 32'(PENABLE), 32'd0);
      chk("mid_rst_hreadyout", 32'(HREADYOUT), 32'd1);
      chk("mid_rst_hresp", 32'(HRESP), 32'd0);
      chk("mid_rst_paddr", PADDR, 32'd0);
      chk("mid_rst_pwrite", 32'(PWRITE), 32'd0);
      chk("mid_rst_pwdata", PWDATA, 32'd0);
      chk("mid_rst_hrdata", HRDATA, 32'd0);
      HRESET = 1'b0;
      apb_q.delete();
      ahb_q.delete();
      exp_hrdata = '0;
      @(negedge HCLK);
      rst_test = 1'b0;
      issue(32'h4000_0080, 1'b0, 32'h0, 0, 1'b0, 32'h7777_8888, 0);
      n = 0;
      while (ahb_q.size() > 0 && n < 50) begin
         set_junk(!HREADYOUT);
         @(negedge HCLK);
         n++;
      end
      chk("final_pending", 32'(ahb_q.size()), 32'd0);
      @(negedge HCLK);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
